// File: rtl/mul_if.sv
// Handshake and write-back bundle between the execute-stage controller and mul_unit.
interface mul_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              flush;
  logic              accumulate;
  logic              set_flags;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  op_c;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              we_out;
  logic [ADDR_W-1:0] wa_out;
  logic [WIDTH-1:0]  wd_out;
  logic              flags_we;
  logic              flag_n;
  logic              flag_z;

  modport master (
    output start, flush, accumulate, set_flags, op_a, op_b, op_c, rd_addr,
    input  busy, done, we_out, wa_out, wd_out, flags_we, flag_n, flag_z
  );

  modport slave (
    input  start, flush, accumulate, set_flags, op_a, op_b, op_c, rd_addr,
    output busy, done, we_out, wa_out, wd_out, flags_we, flag_n, flag_z
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit: WIDTH iterations, one-cycle done pulse, registered write-back.
module mul_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  mul_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              sf_q, sf_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              flags_we_q, flags_we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [WIDTH-1:0]  wd_q, wd_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    rd_d       = rd_q;
    sf_d       = sf_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    we_d       = 1'b0;
    flags_we_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    flag_n_d   = flag_n_q;
    flag_z_d   = flag_z_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d  = RUN;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          acc_d    = bus.accumulate ? bus.op_c : '0;
          rd_d     = bus.rd_addr;
          sf_d     = bus.set_flags;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // Outputs lag the state by one edge so busy covers the visible done cycle
        if (!bus.flush) begin
          busy_d     = 1'b1;
          done_d     = 1'b1;
          we_d       = (rd_q != '1);
          flags_we_d = sf_q;
          wa_d       = rd_q;
          wd_d       = acc_q;
          flag_n_d   = acc_q[WIDTH-1];
          flag_z_d   = (acc_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      sf_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      flags_we_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      flag_n_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      sf_q       <= sf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      flags_we_q <= flags_we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      flag_n_q   <= flag_n_d;
      flag_z_q   <= flag_z_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.we_out   = we_q;
  assign bus.flags_we = flags_we_q;
  assign bus.wa_out   = wa_q;
  assign bus.wd_out   = wd_q;
  assign bus.flag_n   = flag_n_q;
  assign bus.flag_z   = flag_z_q;
endmodule

// File: tb/tb_mul_unit.sv
// Directed plus random test of mul_unit against an arithmetic reference model.
module tb_mul_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_wd;

  mul_if #(.WIDTH(32), .ADDR_W(4)) bus ();

  mul_unit #(.WIDTH(32), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [31:0] a, b, c, input logic acc_en);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p) + (acc_en ? c : 32'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; pulse_k>=0 raises start for one cycle at that negedge after E0
  task automatic run_op(input logic [31:0] a, b, c, input logic acc_en, sf,
                        input logic [3:0] rd, input int pulse_k);
    logic [31:0] res;
    int busy_cnt, done_cnt, done_k;
    res = ref_result(a, b, c, acc_en);
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.op_c = c;
    bus.accumulate = acc_en; bus.set_flags = sf; bus.rd_addr = rd;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.op_c = $urandom;
    bus.accumulate = 1'($urandom); bus.set_flags = 1'($urandom);
    bus.rd_addr = 4'($urandom);
    for (int k = 0; k < 50; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_k = k;
        chk("we_out",   32'(bus.we_out),   32'(rd != 4'd15));
        chk("flags_we", 32'(bus.flags_we), 32'(sf));
        chk("wa_out",   32'(bus.wa_out),   32'(rd));
        chk("wd_out",   bus.wd_out,        res);
        chk("flag_n",   32'(bus.flag_n),   32'(res[31]));
        chk("flag_z",   32'(bus.flag_z),   32'(res == 32'd0));
      end
      if (!bus.busy) break;
      bus.start = (k == pulse_k);
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("done_latency", 32'(done_k), 32'd33);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd34);
    chk("wd_hold", bus.wd_out, res);
    repeat (3) @(negedge clk);
    chk("idle_after", 32'(bus.busy), 32'd0);
    last_wd = res;
  endtask

  initial begin
    int done_seen;
    int done_ks[$];
    checks = 0; errors = 0; last_wd = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.accumulate = 1'b0; bus.set_flags = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.op_c = '0; bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wd", bus.wd_out, 32'd0);
    chk("rst_flagz", 32'(bus.flag_z), 32'd0);
    rst_n = 1'b1;

    run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'd3, -1);
    run_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'd4, -1);
    run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'd5, -1);
    run_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b1, 4'd6, -1);
    run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'd15, -1);
    run_op(32'd100, 32'd200, 32'd1, 1'b1, 1'b0, 4'd1, 5);
    run_op(32'd17, 32'd19, 32'd0, 1'b0, 1'b0, 4'd2, 32);
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), -1);

    // start held for 80 cycles: completions every 34 cycles
    @(negedge clk);
    bus.op_a = 32'd5; bus.op_b = 32'd9; bus.op_c = 32'd0;
    bus.accumulate = 1'b0; bus.set_flags = 1'b0; bus.rd_addr = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_ks.push_back(k);
        chk("held_wd", bus.wd_out, 32'd45);
      end
      if (k == 79) bus.start = 1'b0;
    end
    chk("held_count", 32'(done_ks.size()), 32'd3);
    if (done_ks.size() == 3) begin
      chk("held_first", 32'(done_ks[0]), 32'd33);
      chk("held_gap1", 32'(done_ks[1] - done_ks[0]), 32'd34);
      chk("held_gap2", 32'(done_ks[2] - done_ks[1]), 32'd34);
    end
    last_wd = 32'd45;

    // flush at RUN cycle 10
    @(negedge clk);
    bus.op_a = 32'd11; bus.op_b = 32'd13; bus.rd_addr = 4'd8; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.we_out || bus.flags_we) done_seen++;
    end
    chk("flush_nodone", 32'(done_seen), 32'd0);
    chk("flush_wd", bus.wd_out, last_wd);

    // asynchronous reset at RUN cycle 20
    @(negedge clk);
    bus.op_a = 32'd21; bus.op_b = 32'd23; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_wd", bus.wd_out, 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_wd = '0;
    run_op(32'hDEAD_BEEF, 32'h0000_1001, 32'd0, 1'b0, 1'b1, 4'd9, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
